// File: rtl/hazard_unit_pkg.sv
// Shared encodings, the A/T stage record and helpers for the hazard unit.
// Forward selects, Tuse/Tnew constants, sat_dec and the forwarding priority pick.
package hazard_unit_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_FROM_E  = 2'd1;
   localparam logic [1:0] FWD_FROM_M  = 2'd2;
   localparam logic [1:0] FWD_FROM_W  = 2'd3;

   localparam logic [1:0] TUSE_D = 2'd0;
   localparam logic [1:0] TUSE_E = 2'd1;
   localparam logic [1:0] TUSE_M = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_NONE = 2'd0;
   localparam logic [1:0] TNEW_E    = 2'd1;
   localparam logic [1:0] TNEW_M    = 2'd2;
   localparam logic [1:0] TNEW_W    = 2'd3;

   typedef struct packed {
      logic [4:0] a1;
      logic [4:0] a2;
      logic [4:0] a3;
      logic [1:0] tnew;
   } at_rec_t;

   function automatic logic [1:0] sat_dec(input logic [1:0] x);
      return (x != 2'd0) ? x - 2'd1 : 2'd0;
   endfunction

   // $0 is hard-wired, so it never aliases a producer.
   function automatic logic hit(input logic [4:0] addr, input at_rec_t r);
      return (addr != 5'd0) && (addr == r.a3);
   endfunction

   // Youngest matching stage wins; a not-yet-ready match masks older stages.
   function automatic logic [1:0] fwd_pick(input logic [4:0] addr,
                                           input logic use_e, input logic use_m,
                                           input at_rec_t e, input at_rec_t m,
                                           input at_rec_t w);
      logic [1:0] sel;
      sel = FWD_REGFILE;
      if (use_e && hit(addr, e))
         sel = (e.tnew == 2'd0) ? FWD_FROM_E : FWD_REGFILE;
      else if (use_m && hit(addr, m))
         sel = (m.tnew == 2'd0) ? FWD_FROM_M : FWD_REGFILE;
      else if (hit(addr, w))
         sel = (w.tnew == 2'd0) ? FWD_FROM_W : FWD_REGFILE;
      return sel;
   endfunction

endpackage

// File: rtl/hazard_unit_at_stage_reg.sv
// One pipeline A/T record register; counts tnew down as the record advances.
module at_stage_reg
   import hazard_unit_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    bubble,
   input  at_rec_t d,
   output at_rec_t q
);

   always_ff @(posedge clk) begin
      if (reset || bubble)
         q <= '0;
      else
         q <= '{a1: d.a1, a2: d.a2, a3: d.a3, tnew: sat_dec(d.tnew)};
   end

endmodule

// File: rtl/hazard_unit.sv
// Stall and forwarding control from E/M/W address/timing records (A-T method).
// All outputs are combinational from D inputs and the current records.
module hazard_unit
   import hazard_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] A1_D,
   input  logic [4:0] A2_D,
   input  logic [4:0] A3_D,
   input  logic [1:0] Tuse1_D,
   input  logic [1:0] Tuse2_D,
   input  logic [1:0] Tnew_D,
   input  logic       MDUreq_D,
   input  logic       mdu_start,
   input  logic       mdu_busy,
   output logic       stall,
   output logic [1:0] fwd_rs_D,
   output logic [1:0] fwd_rt_D,
   output logic [1:0] fwd_rs_E,
   output logic [1:0] fwd_rt_E,
   output logic [1:0] fwd_rt_M
);

   at_rec_t rec_d, rec_e, rec_m, rec_w;
   logic    stall_data, stall_mdu;

   assign rec_d = '{a1: A1_D, a2: A2_D, a3: A3_D, tnew: Tnew_D};

   at_stage_reg u_rec_e (.clk(clk), .reset(reset), .bubble(stall), .d(rec_d), .q(rec_e));
   at_stage_reg u_rec_m (.clk(clk), .reset(reset), .bubble(1'b0),  .d(rec_e), .q(rec_m));
   at_stage_reg u_rec_w (.clk(clk), .reset(reset), .bubble(1'b0),  .d(rec_m), .q(rec_w));

   // W never needs a stall: any producer reaching W has tnew 0.
   assign stall_data = (hit(A1_D, rec_e) && (rec_e.tnew > Tuse1_D)) ||
                       (hit(A1_D, rec_m) && (rec_m.tnew > Tuse1_D)) ||
                       (hit(A2_D, rec_e) && (rec_e.tnew > Tuse2_D)) ||
                       (hit(A2_D, rec_m) && (rec_m.tnew > Tuse2_D));

   assign stall_mdu = MDUreq_D && (mdu_busy || mdu_start);
   assign stall     = stall_data || stall_mdu;

   assign fwd_rs_D = fwd_pick(A1_D,     1'b1, 1'b1, rec_e, rec_m, rec_w);
   assign fwd_rt_D = fwd_pick(A2_D,     1'b1, 1'b1, rec_e, rec_m, rec_w);
   assign fwd_rs_E = fwd_pick(rec_e.a1, 1'b0, 1'b1, rec_e, rec_m, rec_w);
   assign fwd_rt_E = fwd_pick(rec_e.a2, 1'b0, 1'b1, rec_e, rec_m, rec_w);
   assign fwd_rt_M = fwd_pick(rec_m.a2, 1'b0, 1'b0, rec_e, rec_m, rec_w);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: stall and forwarding across instruction pairs.
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] A1_D = '0, A2_D = '0, A3_D = '0;
   logic [1:0] Tuse1_D = '0, Tuse2_D = '0, Tnew_D = '0;
   logic       MDUreq_D = 1'b0, mdu_start = 1'b0, mdu_busy = 1'b0;
   logic       stall;
   logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;

   int checks = 0;
   int errors = 0;

   hazard_unit dut (
      .clk(clk), .reset(reset),
      .A1_D(A1_D), .A2_D(A2_D), .A3_D(A3_D),
      .Tuse1_D(Tuse1_D), .Tuse2_D(Tuse2_D), .Tnew_D(Tnew_D),
      .MDUreq_D(MDUreq_D), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
      .stall(stall),
      .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
      .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                        input logic [1:0] tu1, input logic [1:0] tu2, input logic [1:0] tn,
                        input logic mreq);
      A1_D = a1; A2_D = a2; A3_D = a3;
      Tuse1_D = tu1; Tuse2_D = tu2; Tnew_D = tn; MDUreq_D = mreq;
   endtask

   task automatic do_reset();
      set_d(0, 0, 0, 3, 3, 0, 0);
      mdu_start = 0; mdu_busy = 0;
      reset = 1; step(); step(); reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      set_d(3, 4, 0, 0, 0, 0, 0);   // beq $3,$4 with empty pipeline
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      checks++; if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M} !== 10'd0) begin errors++;
         $display("FAIL reset_fwd: got %b want 0", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M}); end
      set_d(0, 0, 10, 3, 3, 2, 1); mdu_busy = 1;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_mdu_stall: got %b want 1", stall); end
      mdu_busy = 0;
   endtask

   task automatic test_alu_branch();
      do_reset();
      set_d(1, 2, 3, 1, 1, 2, 0);   // addu $3,$1,$2
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_br_first: got %b want 0", stall); end
      step();
      set_d(3, 4, 0, 0, 0, 0, 0);   // beq $3,$4
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL alu_br_stall: got %b want 1", stall); end
      step();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_br_release: got %b want 0", stall); end
      checks++; if (fwd_rs_D !== FWD_FROM_M) begin errors++; $display("FAIL alu_br_fwd: got %0d want 2", fwd_rs_D); end
      checks++; if (fwd_rt_D !== FWD_REGFILE) begin errors++; $display("FAIL alu_br_rt: got %0d want 0", fwd_rt_D); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_d(29, 0, 5, 1, 3, 3, 0);  // lw $5,0($29)
      step();
      set_d(5, 5, 6, 1, 1, 2, 0);   // addu $6,$5,$5
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_use_stall: got %b want 1", stall); end
      step();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_use_release: got %b want 0", stall); end
      checks++; if (fwd_rs_D !== FWD_REGFILE) begin errors++; $display("FAIL ld_use_notready: got %0d want 0", fwd_rs_D); end
      step();
      set_d(0, 0, 0, 3, 3, 0, 0);
      #1;
      checks++; if (fwd_rs_E !== FWD_FROM_W) begin errors++; $display("FAIL ld_use_rsE: got %0d want 3", fwd_rs_E); end
      checks++; if (fwd_rt_E !== FWD_FROM_W) begin errors++; $display("FAIL ld_use_rtE: got %0d want 3", fwd_rt_E); end
   endtask

   task automatic test_load_branch();
      int n;
      do_reset();
      set_d(29, 0, 5, 1, 3, 3, 0);  // lw $5
      step();
      set_d(5, 0, 0, 0, 0, 0, 0);   // beq $5,$0
      n = 0;
      for (int i = 0; i < 2; i++) begin
         #1; if (stall === 1'b1) n++;
         step();
      end
      #1;
      checks++; if (n !== 2) begin errors++; $display("FAIL ld_br_cycles: got %0d want 2", n); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_br_release: got %b want 0", stall); end
      checks++; if (fwd_rs_D !== FWD_FROM_W) begin errors++; $display("FAIL ld_br_fwd: got %0d want 3", fwd_rs_D); end
   endtask

   task automatic test_jal_jr();
      do_reset();
      set_d(0, 0, 31, 3, 3, 1, 0);  // jal
      step();
      set_d(31, 0, 0, 0, 3, 0, 0);  // jr $31
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jal_jr_stall: got %b want 0", stall); end
      checks++; if (fwd_rs_D !== FWD_FROM_E) begin errors++; $display("FAIL jal_jr_fwd: got %0d want 1", fwd_rs_D); end
   endtask

   task automatic test_mdu();
      int n;
      do_reset();
      set_d(8, 9, 0, 1, 1, 0, 1);   // mult $8,$9
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mdu_idle: got %b want 0", stall); end
      step();
      set_d(0, 0, 10, 3, 3, 2, 1);  // mflo $10
      n = 0;
      for (int i = 0; i < 8; i++) begin
         mdu_busy = (i < 5);
         #1; if (stall === 1'b1) n++;
         step();
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL mdu_cycles: got %0d want 5", n); end
      mdu_start = 1;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mdu_start: got %b want 1", stall); end
      mdu_start = 0; mdu_busy = 1;
      set_d(1, 2, 11, 1, 1, 2, 0);  // addu, no MDU use
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mdu_noreq: got %b want 0", stall); end
      mdu_busy = 0;
   endtask

   task automatic test_zero_reg();
      do_reset();
      set_d(1, 2, 0, 1, 1, 2, 0);   // addu $0,$1,$2
      step();
      set_d(0, 0, 0, 0, 0, 0, 0);   // beq $0,$0
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", stall); end
      checks++; if ({fwd_rs_D, fwd_rt_D} !== 4'd0) begin errors++;
         $display("FAIL zero_fwd: got %b want 0", {fwd_rs_D, fwd_rt_D}); end
      step();
      checks++; if ({fwd_rs_D, fwd_rt_D} !== 4'd0) begin errors++;
         $display("FAIL zero_fwd_m: got %b want 0", {fwd_rs_D, fwd_rt_D}); end
   endtask

   task automatic test_load_store();
      do_reset();
      set_d(29, 0, 7, 1, 3, 3, 0);  // lw $7
      step();
      set_d(29, 7, 0, 1, 2, 0, 0);  // sw $7,0($29)
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_st_stall: got %b want 0", stall); end
      step();
      set_d(0, 0, 0, 3, 3, 0, 0);
      #1;
      checks++; if (fwd_rt_E !== FWD_REGFILE) begin errors++; $display("FAIL ld_st_rtE: got %0d want 0", fwd_rt_E); end
      step();
      checks++; if (fwd_rt_M !== FWD_FROM_W) begin errors++; $display("FAIL ld_st_rtM: got %0d want 3", fwd_rt_M); end
   endtask

   task automatic test_priority();
      do_reset();
      set_d(1, 2, 4, 1, 1, 2, 0);   // addu $4
      step();
      set_d(0, 0, 4, 3, 3, 1, 0);   // lui $4 (ready out of E)
      step();
      set_d(4, 0, 12, 1, 3, 2, 0);  // reads $4 in E
      #1;
      checks++; if (fwd_rs_D !== FWD_FROM_E) begin errors++; $display("FAIL prio_e_over_m: got %0d want 1", fwd_rs_D); end
      do_reset();
      set_d(1, 2, 4, 1, 1, 2, 0);   // addu $4
      step();
      set_d(29, 0, 4, 1, 3, 3, 0);  // lw $4 (not ready in E)
      step();
      set_d(29, 4, 0, 1, 2, 0, 0);  // sw $4: E match blocks older M
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL prio_block_stall: got %b want 0", stall); end
      checks++; if (fwd_rt_D !== FWD_REGFILE) begin errors++; $display("FAIL prio_block_fwd: got %0d want 0", fwd_rt_D); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_d(29, 0, 5, 1, 3, 3, 0);  // lw $5
      step();
      set_d(5, 5, 6, 1, 1, 2, 0);   // addu $6,$5,$5
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b want 1", stall); end
      reset = 1;
      step();
      reset = 0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
      checks++; if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M} !== 10'd0) begin errors++;
         $display("FAIL rst_mid_fwd: got %b want 0", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M}); end
   endtask

   initial begin
      test_reset();
      test_alu_branch();
      test_load_use();
      test_load_branch();
      test_jal_jr();
      test_mdu();
      test_zero_reg();
      test_load_store();
      test_priority();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports `clk`, `reset`, both inputs, 1 bit; one clock, synchronous active-high reset.
REQ-002 SHALL have `A1_D`, `A2_D`, `A3_D`: input, 5 bits each; D-stage source/destination register numbers from the AT decoder.
REQ-003 SHALL have `Tuse1_D`, `Tuse2_D`, `Tnew_D`: input, 2 bits each; decoder timing fields.
- Tuse: stage offset from D at which the operand is consumed (0=D, 1=E, 2=M).
- Tnew: stages from D until the result is forwardable.
REQ-004 SHALL have `MDUreq_D`: input, 1 bit; D instruction uses multiply/divide unit or HI/LO.
REQ-005 SHALL have `mdu_start`, `mdu_busy`: input, 1 bit each; E-stage MDU start pulse and MDU busy.
REQ-006 SHALL have `stall`: output, 1 bit; freeze PC and the D register, insert bubble into E.
REQ-007 SHALL have `fwd_rs_D`, `fwd_rt_D`: output, 2 bits each; D operand source (0=regfile, 1=E, 2=M, 3=W).
REQ-008 SHALL have `fwd_rs_E`, `fwd_rt_E`: output, 2 bits each; E operand source (0=own pipeline value, 2=M, 3=W).
REQ-009 SHALL have `fwd_rt_M`: output, 2 bits; M store-data source (0=own, 3=W).

Function
REQ-010 SHALL hold three stage records (E, M, W), each {a1, a2, a3, tnew}.
REQ-011 SHALL advance records every cycle:
- E <- D fields, with tnew = sat_dec(Tnew_D).
- M <- E, with tnew = sat_dec(tnew_E).
- W <- M, with tnew = sat_dec(tnew_M).
- sat_dec(x) = x>0 ? x-1 : 0.
REQ-012 SHALL, when `stall`=1, load E with a bubble (all fields 0) while M and W still advance.
REQ-013 SHALL define a match as: operand address nonzero and equal to a stage's a3; register 0 never matches.
REQ-014 SHALL assert data stall when any D operand k in {1,2} matches stage S in {E,M} with tnew_S > Tuse_k_D.
REQ-015 SHALL assert MDU stall when `MDUreq_D`=1 and (`mdu_busy`=1 or `mdu_start`=1).
REQ-016 SHALL drive `stall` combinationally as data stall OR MDU stall; simultaneous causes produce a single stall.
REQ-017 SHALL select forwarding as the youngest matching stage with tnew=0, in priority order E > M > W; otherwise 0.
REQ-018 SHALL restrict D-stage forwarding to sources E, M, W; E-stage to M, W; M-stage to W.
REQ-019 SHALL never select a stage whose matching tnew is nonzero; in that case the older stage is not selected for that operand either.
REQ-020 SHALL make all outputs combinational from current inputs and records; zero cycles of latency.
REQ-021 SHALL stall a lw followed by a dependent branch for 2 cycles, and a lw followed by a dependent ALU op for 1 cycle.

Reset
REQ-022 SHALL clear all E/M/W records to 0 on the rising `clk` edge while `reset`=1.
REQ-023 SHALL, after reset, drive `stall` from D inputs only and all fwd outputs to 0.
REQ-024 SHALL let reset asserted mid-stall take precedence over record advance; stall resumes only if D inputs still demand it.

Structure
REQ-025 SHALL place fwd-select encodings (REGFILE=0, FROM_E=1, FROM_M=2, FROM_W=3) and Tuse/Tnew constants in the shared define file.
REQ-026 SHALL implement one sub-module, `at_stage_reg`: a record register with bubble and sat_dec, instantiated three times.

Verification
REQ-027 SHALL cover: `addu $3` (Tnew 2) then `beq $3` (Tuse 0) -> `stall`=1 for 1 cycle, then `fwd_rs_D`=2.
REQ-028 SHALL cover: `lw $5` (Tnew 3) then `addu $6,$5,$5` -> `stall`=1 for 1 cycle; next cycle `fwd_rs_E`=`fwd_rt_E`=3.
REQ-029 SHALL cover: `jal` (A3=31, Tnew 1) then `jr $31` -> no stall, `fwd_rs_D`=1.
REQ-030 SHALL cover: `mult` with `mdu_busy`=1 for 5 cycles, `mflo` in D -> `stall`=1 for exactly 5 cycles; zero-register dest `addu $0` then `beq $0` -> no stall, fwd 0.
REQ-031 SHALL cover: `lw $7` then `sw $7` (rt Tuse 2) -> no stall, `fwd_rt_M`=3 two cycles later.
REQ-032 SHALL cover: `reset`=1 during a lw-induced stall -> records cleared next edge, all fwd outputs 0.
